wm8731_audio_slave_transceiver: RTL and testbench
=================================================

// Module: wm8731_audio_slave_transceiver
// PURPOSE
//  I2S slave-mode audio transceiver for the WM8731 with the codec as bus master.
//  The codec drives AUD_BCLK, AUD_DACLRCK and AUD_ADCLRCK into the FPGA.
//  The block serialises DAC samples onto AUD_DACDAT and deserialises AUD_ADCDAT into ADC samples.
//  It presents the same channel data/trigger/ready handshake as the existing master-mode transceiver.
// PARAMETERS
//  SAMPLE_BITS  16  bits per channel sample; MSB first
//  SYNC_STAGES  2   synchroniser flops on each codec input (min 2)
// PORTS
//  CLK              in   1   system clock; must be >= 8x AUD_BCLK
//  RESET            in   1   synchronous, active-high reset
//  ENABLE           in   1   1 = run; 0 = halt and resynchronise (tie to config complete)
//  DAC_LCHAN_DATA   in   SB  left sample; latched on left-channel load
//  DAC_RCHAN_DATA   in   SB  right sample; latched on right-channel load
//  DAC_LCHAN_TRIG   out  1   1-CLK pulse: left sample latched, next may be presented
//  DAC_RCHAN_TRIG   out  1   1-CLK pulse: right sample latched
//  ADC_LCHAN_READY  out  1   1-CLK pulse: ADC_LCHAN_DATA updated
//  ADC_LCHAN_DATA   out  SB  last complete left ADC sample; held between updates
//  ADC_RCHAN_READY  out  1   1-CLK pulse: ADC_RCHAN_DATA updated
//  ADC_RCHAN_DATA   out  SB  last complete right ADC sample
//  FRAME_ERROR      out  1   sticky: an LRCK edge arrived before SAMPLE_BITS bits
//  AUD_BCLK         in   1   codec bit clock
//  AUD_DACLRCK      in   1   DAC frame clock; 0 = left, 1 = right
//  AUD_DACDAT       out  1   serial DAC data
//  AUD_ADCLRCK      in   1   ADC frame clock; 0 = left, 1 = right
//  AUD_ADCDAT       in   1   serial ADC data
// BEHAVIOUR
//  - Reset: all outputs 0, ADC data registers 0, both paths in IDLE.
//  - Inputs pass through SYNC_STAGES flops.
//  - Edge detect produces single-CLK bclk_rise and bclk_fall strobes.
//  - DAC path states: IDLE -> DELAY -> SHIFT -> PAD.
//    - At each bclk_fall, sample DACLRCK and compare with the previous sample.
//    - On a change: latch DAC_LCHAN_DATA (new LRCK 0) or DAC_RCHAN_DATA (new LRCK 1) into the shifter.
//    - Pulse the matching TRIG on the next CLK. Drive DACDAT 0 (I2S 1-bit delay). Enter DELAY.
//    - Next bclk_fall: drive MSB, enter SHIFT.
//    - SHIFT: one bit per bclk_fall. After SAMPLE_BITS bits, enter PAD with DACDAT 0 until the next LRCK change.
//    - LRCK change while in DELAY/SHIFT: set FRAME_ERROR, abandon the remaining bits, perform a normal load.
//  - ADC path uses the same state set, clocked on bclk_rise.
//    - An ADCLRCK change enters DELAY, which skips one bit. SHIFT captures SAMPLE_BITS bits MSB first.
//    - On the last bit: copy to the channel register selected by LRCK level at frame start.
//    - Pulse READY <= 2 CLK after that bclk_rise strobe.
//    - LRCK change mid-capture: set FRAME_ERROR, discard partial sample, no READY, start a new frame.
//  - First LRCK change after reset or ENABLE rise only synchronises. No TRIG/READY until a full frame.
//  - ENABLE=0: both paths forced to IDLE, DACDAT 0, no TRIG/READY. ADC data and FRAME_ERROR held.
//  - DAC and ADC paths are independent. L and R TRIG never coincide; L and R READY never coincide.
//  - Sample width is exact: no sign extension or truncation.
//  - Bits after SAMPLE_BITS in a channel slot are ignored on ADC and driven 0 on DAC.
//  - FRAME_ERROR clears only on RESET.
// CONFIGURATION
//  - AUD_SLAVE_LOOPBACK_EN defined: the ADC shifter takes its input from the internal AUD_DACDAT register.
//    AUD_ADCDAT is ignored; AUD_ADCLRCK is still used for framing.
//  - Undefined: the ADC shifter takes its input from synchronised AUD_ADCDAT. No loopback logic present.
// TESTING
//  1. RESET high 3 CLK mid-frame -> all outputs 0; DACDAT 0 until a full new frame.
//  2. BCLK=CLK/16, 32 BCLK/channel, L=16'hA5C3, R=16'h3C5A
//     -> DACDAT carries A5C3/3C5A MSB-first from 2nd BCLK of each slot.
//     -> One TRIG pulse per LRCK edge.
//  3. ADCDAT drives L=16'h8001, R=16'h7FFE
//     -> ADC_LCHAN_DATA=16'h8001 with 1-CLK READY, then ADC_RCHAN_DATA=16'h7FFE.
//  4. ADCLRCK toggles after 10 bits -> FRAME_ERROR=1, no READY.
//     The next full frame with 16'h1234 is captured correctly.
//  5. ENABLE low mid-SHIFT -> DACDAT 0 within SYNC_STAGES+2 CLK, no pulses.
//     Re-enable mid-slot -> first TRIG only after second LRCK edge.
//  6. With AUD_SLAVE_LOOPBACK_EN, shared LRCK, L=16'h5A5A, ADCDAT tied 1 -> ADC_LCHAN_DATA=16'h5A5A.

Source files
------------

// File: rtl/wm8731_audio_slave_transceiver.sv
// wm8731_audio_slave_transceiver
//   I2S slave-mode transceiver for the WM8731 running as bus master. The codec
//   drives BCLK and both LRCKs; this block serialises DAC samples onto
//   AUD_DACDAT and deserialises AUD_ADCDAT into per-channel ADC samples.
//
//   Optional feature macro: AUD_SLAVE_LOOPBACK_EN
//     defined   : the ADC shifter is fed from the internal AUD_DACDAT register;
//                 AUD_ADCDAT is ignored, AUD_ADCLRCK still frames the capture.
//     undefined : the ADC shifter is fed from the synchronised AUD_ADCDAT pin.
//
// Ports
//   CLK, RESET          system clock (>= 8x BCLK), synchronous active-high reset
//   ENABLE              1 = run, 0 = halt both paths and resynchronise
//   DAC_[LR]CHAN_DATA   samples latched on the matching channel load
//   DAC_[LR]CHAN_TRIG   1-CLK pulse: sample latched, next one may be presented
//   ADC_[LR]CHAN_READY  1-CLK pulse: ADC_[LR]CHAN_DATA was just updated
//   ADC_[LR]CHAN_DATA   last complete ADC sample per channel, held in between
//   FRAME_ERROR         sticky: LRCK changed before SAMPLE_BITS bits were moved
//   AUD_*               codec pins (BCLK, DACLRCK, DACDAT, ADCLRCK, ADCDAT)
//   DAC_STATE/ADC_STATE current path FSM state (IDLE=0, DELAY=1, SHIFT=2, PAD=3)
//
// Handshake: there is no back-pressure. TRIG/READY are single-cycle strobes;
// the consumer must accept ADC data and present the next DAC sample before the
// next channel slot begins (one LRCK half-period).
module wm8731_audio_slave_transceiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic [SAMPLE_BITS-1:0] DAC_LCHAN_DATA,
    input  logic [SAMPLE_BITS-1:0] DAC_RCHAN_DATA,
    output logic                   DAC_LCHAN_TRIG,
    output logic                   DAC_RCHAN_TRIG,
    output logic                   ADC_LCHAN_READY,
    output logic [SAMPLE_BITS-1:0] ADC_LCHAN_DATA,
    output logic                   ADC_RCHAN_READY,
    output logic [SAMPLE_BITS-1:0] ADC_RCHAN_DATA,
    output logic                   FRAME_ERROR,
    input  logic                   AUD_BCLK,
    input  logic                   AUD_DACLRCK,
    output logic                   AUD_DACDAT,
    input  logic                   AUD_ADCLRCK,
    input  logic                   AUD_ADCDAT,
    output logic [1:0]             DAC_STATE,
    output logic [1:0]             ADC_STATE
);
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLE_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, SHIFT = 2'd2, PAD = 2'd3} path_state_e;

    // ---------------- input synchronisers and BCLK edge strobes ----------------
    logic [SYNC_STAGES-1:0] bclk_sr, dlrck_sr, alrck_sr;
    logic bclk_prev, bclk_s, dlrck_s, alrck_s, bclk_rise, bclk_fall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bclk_sr   <= '0;
            dlrck_sr  <= '0;
            alrck_sr  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sr   <= {bclk_sr[SYNC_STAGES-2:0], AUD_BCLK};
            dlrck_sr  <= {dlrck_sr[SYNC_STAGES-2:0], AUD_DACLRCK};
            alrck_sr  <= {alrck_sr[SYNC_STAGES-2:0], AUD_ADCLRCK};
            bclk_prev <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sr[SYNC_STAGES-1];
    assign dlrck_s   = dlrck_sr[SYNC_STAGES-1];
    assign alrck_s   = alrck_sr[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign bclk_fall = ~bclk_s & bclk_prev;

    // ---------------- DAC path (advances on BCLK falling edges) ----------------
    path_state_e dac_state, dac_next;
    logic [SAMPLE_BITS-1:0] dac_shreg;
    logic [CW-1:0] dac_cnt;
    logic dac_lrck_prev, dac_primed, dac_dat, dac_change;
    logic dac_load, dac_shift, dac_err;

    // primed is cleared on reset/disable so the first LRCK sample only seeds prev
    assign dac_change = dac_primed && (dlrck_s != dac_lrck_prev);

    always_ff @(posedge CLK) begin
        if (RESET) dac_state <= IDLE;
        else       dac_state <= dac_next;
    end

    always_comb begin
        dac_next  = dac_state;
        dac_load  = 1'b0;
        dac_shift = 1'b0;
        dac_err   = 1'b0;
        if (!ENABLE) begin
            dac_next = IDLE;
        end else if (bclk_fall) begin
            if (dac_change) begin
                if (dac_state == IDLE) begin
                    // first edge after reset/enable only establishes frame phase
                    dac_next = PAD;
                end else begin
                    dac_next = DELAY;
                    dac_load = 1'b1;
                    dac_err  = (dac_state == DELAY) ||
                               ((dac_state == SHIFT) && (dac_cnt != LAST_CNT));
                end
            end else if (dac_state == DELAY) begin
                dac_shift = 1'b1;
                dac_next  = SHIFT;
            end else if (dac_state == SHIFT) begin
                if (dac_cnt == LAST_CNT) dac_next = PAD;
                else                     dac_shift = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dac_shreg      <= '0;
            dac_cnt        <= '0;
            dac_lrck_prev  <= 1'b0;
            dac_primed     <= 1'b0;
            dac_dat        <= 1'b0;
            DAC_LCHAN_TRIG <= 1'b0;
            DAC_RCHAN_TRIG <= 1'b0;
        end else begin
            DAC_LCHAN_TRIG <= 1'b0;
            DAC_RCHAN_TRIG <= 1'b0;
            if (!ENABLE) begin
                dac_dat    <= 1'b0;
                dac_primed <= 1'b0;
            end else if (bclk_fall) begin
                dac_lrck_prev <= dlrck_s;
                dac_primed    <= 1'b1;
                if (dac_load) begin
                    // the load edge carries the I2S one-bit delay slot (driven 0)
                    dac_shreg      <= dlrck_s ? DAC_RCHAN_DATA : DAC_LCHAN_DATA;
                    dac_cnt        <= '0;
                    dac_dat        <= 1'b0;
                    DAC_LCHAN_TRIG <= ~dlrck_s;
                    DAC_RCHAN_TRIG <= dlrck_s;
                end else if (dac_shift) begin
                    dac_dat   <= dac_shreg[SAMPLE_BITS-1];
                    dac_shreg <= dac_shreg << 1;
                    dac_cnt   <= dac_cnt + 1'b1;
                end else begin
                    dac_dat <= 1'b0;
                end
            end
        end
    end

    assign AUD_DACDAT = dac_dat;
    assign DAC_STATE  = dac_state;

    // ---------------- ADC path (advances on BCLK rising edges) ----------------
    logic adc_bit;
`ifdef AUD_SLAVE_LOOPBACK_EN
    assign adc_bit = dac_dat;
`else
    logic [SYNC_STAGES-1:0] adat_sr;
    always_ff @(posedge CLK) begin
        if (RESET) adat_sr <= '0;
        else       adat_sr <= {adat_sr[SYNC_STAGES-2:0], AUD_ADCDAT};
    end
    assign adc_bit = adat_sr[SYNC_STAGES-1];
`endif

    path_state_e adc_state, adc_next;
    logic [SAMPLE_BITS-1:0] adc_shreg, adc_word;
    logic [CW-1:0] adc_cnt;
    logic adc_lrck_prev, adc_primed, adc_chan, adc_change;
    logic adc_load, adc_cap, adc_err;

    assign adc_change = adc_primed && (alrck_s != adc_lrck_prev);
    assign adc_word   = {adc_shreg[SAMPLE_BITS-2:0], adc_bit};

    always_ff @(posedge CLK) begin
        if (RESET) adc_state <= IDLE;
        else       adc_state <= adc_next;
    end

    // The rising edge that reveals the LRCK change is the I2S delay bit, so it
    // is not captured; the MSB arrives on the following rise (first DELAY rise).
    always_comb begin
        adc_next = adc_state;
        adc_load = 1'b0;
        adc_cap  = 1'b0;
        adc_err  = 1'b0;
        if (!ENABLE) begin
            adc_next = IDLE;
        end else if (bclk_rise) begin
            if (adc_change) begin
                if (adc_state == IDLE) begin
                    adc_next = PAD;
                end else begin
                    adc_next = DELAY;
                    adc_load = 1'b1;
                    adc_err  = (adc_state == DELAY) || (adc_state == SHIFT);
                end
            end else if ((adc_state == DELAY) || (adc_state == SHIFT)) begin
                adc_cap  = 1'b1;
                adc_next = (adc_cnt == LAST_BIT) ? PAD : SHIFT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            adc_shreg       <= '0;
            adc_cnt         <= '0;
            adc_lrck_prev   <= 1'b0;
            adc_primed      <= 1'b0;
            adc_chan        <= 1'b0;
            ADC_LCHAN_DATA  <= '0;
            ADC_RCHAN_DATA  <= '0;
            ADC_LCHAN_READY <= 1'b0;
            ADC_RCHAN_READY <= 1'b0;
        end else begin
            ADC_LCHAN_READY <= 1'b0;
            ADC_RCHAN_READY <= 1'b0;
            if (!ENABLE) begin
                adc_primed <= 1'b0;
            end else if (bclk_rise) begin
                adc_lrck_prev <= alrck_s;
                adc_primed    <= 1'b1;
                if (adc_load) begin
                    adc_chan <= alrck_s;
                    adc_cnt  <= '0;
                end else if (adc_cap) begin
                    adc_shreg <= adc_word;
                    adc_cnt   <= adc_cnt + 1'b1;
                    if (adc_cnt == LAST_BIT) begin
                        if (adc_chan) begin
                            ADC_RCHAN_DATA  <= adc_word;
                            ADC_RCHAN_READY <= 1'b1;
                        end else begin
                            ADC_LCHAN_DATA  <= adc_word;
                            ADC_LCHAN_READY <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign ADC_STATE = adc_state;

    // ---------------- sticky frame error ----------------
    always_ff @(posedge CLK) begin
        if (RESET)                   FRAME_ERROR <= 1'b0;
        else if (dac_err || adc_err) FRAME_ERROR <= 1'b1;
    end

endmodule

// File: tb/tb_wm8731_audio_slave_transceiver.sv
// Directed bench for wm8731_audio_slave_transceiver: the bench plays the codec
// (BCLK = CLK/16, 32 BCLK per channel slot, LRCK and ADCDAT change on BCLK fall)
// and samples AUD_DACDAT just before each BCLK rise.
module tb_wm8731_audio_slave_transceiver;
    localparam int SB = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic [SB-1:0] DAC_LCHAN_DATA, DAC_RCHAN_DATA;
    logic          DAC_LCHAN_TRIG, DAC_RCHAN_TRIG;
    logic          ADC_LCHAN_READY, ADC_RCHAN_READY;
    logic [SB-1:0] ADC_LCHAN_DATA, ADC_RCHAN_DATA;
    logic          FRAME_ERROR;
    logic          AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_ADCLRCK, AUD_ADCDAT;
    logic [1:0]    DAC_STATE, ADC_STATE;

    int checks = 0;
    int errors = 0;
    int n_trig_l = 0, n_trig_r = 0, n_rdy_l = 0, n_rdy_r = 0, n_coinc = 0;
    int b_trig_l, b_trig_r, b_rdy_l, b_rdy_r;
    logic [31:0] slot_cap;
    logic        adc_tie_high = 1'b0;

    wm8731_audio_slave_transceiver #(.SAMPLE_BITS(SB), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .DAC_LCHAN_DATA(DAC_LCHAN_DATA), .DAC_RCHAN_DATA(DAC_RCHAN_DATA),
        .DAC_LCHAN_TRIG(DAC_LCHAN_TRIG), .DAC_RCHAN_TRIG(DAC_RCHAN_TRIG),
        .ADC_LCHAN_READY(ADC_LCHAN_READY), .ADC_LCHAN_DATA(ADC_LCHAN_DATA),
        .ADC_RCHAN_READY(ADC_RCHAN_READY), .ADC_RCHAN_DATA(ADC_RCHAN_DATA),
        .FRAME_ERROR(FRAME_ERROR),
        .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
        .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
        .DAC_STATE(DAC_STATE), .ADC_STATE(ADC_STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- pulse monitor (counts cycles each strobe is high) ----------------
    always @(negedge CLK) begin
        if (DAC_LCHAN_TRIG)  n_trig_l++;
        if (DAC_RCHAN_TRIG)  n_trig_r++;
        if (ADC_LCHAN_READY) n_rdy_l++;
        if (ADC_RCHAN_READY) n_rdy_r++;
        if ((DAC_LCHAN_TRIG && DAC_RCHAN_TRIG) || (ADC_LCHAN_READY && ADC_RCHAN_READY)) n_coinc++;
    end

    task automatic snap();
        b_trig_l = n_trig_l; b_trig_r = n_trig_r;
        b_rdy_l  = n_rdy_l;  b_rdy_r  = n_rdy_r;
    endtask

    // ---------------- codec driver ----------------
    task automatic bclk_cycle(input logic dlr, input logic alr, input logic adat, output logic dac_bit);
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = dlr;
        AUD_ADCLRCK = alr;
        AUD_ADCDAT  = adat;
        repeat (7) @(negedge CLK);
        dac_bit = AUD_DACDAT;
        @(negedge CLK);
        AUD_BCLK = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    // Cycles [first,last) of a 32-BCLK slot; ADC word goes out on cycles 1..16.
    task automatic slot_part(input logic dlr, input logic alr, input logic [SB-1:0] aword,
                             input int first, input int last);
        logic b, s;
        for (int i = first; i < last; i++) begin
            if (adc_tie_high)            b = 1'b1;
            else if (i >= 1 && i <= SB)  b = aword[SB - i];
            else                         b = 1'b0;
            bclk_cycle(dlr, alr, b, s);
            slot_cap = {slot_cap[30:0], s};
        end
    endtask

    task automatic slot(input logic lr, input logic [SB-1:0] aword);
        slot_cap = '0;
        slot_part(lr, lr, aword, 0, 32);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0;
        AUD_BCLK = 1'b0; AUD_DACLRCK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
        DAC_LCHAN_DATA = '0; DAC_RCHAN_DATA = '0;
        repeat (5) @(negedge CLK);
        checks++; if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL reset_dacdat got %b expected 0", AUD_DACDAT); end
        checks++; if ({DAC_LCHAN_TRIG, DAC_RCHAN_TRIG, ADC_LCHAN_READY, ADC_RCHAN_READY} !== 4'b0)
            begin errors++; $display("FAIL reset_pulses got %b expected 0000", {DAC_LCHAN_TRIG, DAC_RCHAN_TRIG, ADC_LCHAN_READY, ADC_RCHAN_READY}); end
        checks++; if (ADC_LCHAN_DATA !== 16'h0) begin errors++; $display("FAIL reset_adc_l got %h expected 0000", ADC_LCHAN_DATA); end
        checks++; if (ADC_RCHAN_DATA !== 16'h0) begin errors++; $display("FAIL reset_adc_r got %h expected 0000", ADC_RCHAN_DATA); end
        checks++; if (FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b expected 0", FRAME_ERROR); end
        checks++; if ({DAC_STATE, ADC_STATE} !== 4'b0) begin errors++; $display("FAIL reset_states got %b expected 0000", {DAC_STATE, ADC_STATE}); end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_dac();
        DAC_LCHAN_DATA = 16'hA5C3; DAC_RCHAN_DATA = 16'h3C5A;
        ENABLE = 1'b1;
        snap();
        slot(1'b0, 16'h0000);   // seeds LRCK history
        slot(1'b1, 16'h0000);   // first change: synchronise only
        checks++; if (slot_cap !== 32'h0) begin errors++; $display("FAIL dac_sync_slot got %h expected 00000000", slot_cap); end
        checks++; if ((n_trig_l - b_trig_l) + (n_trig_r - b_trig_r) != 0)
            begin errors++; $display("FAIL dac_sync_trig got %0d expected 0", (n_trig_l - b_trig_l) + (n_trig_r - b_trig_r)); end
        snap();
        slot(1'b0, 16'h0000);
        checks++; if (slot_cap[30:15] !== 16'hA5C3) begin errors++; $display("FAIL dac_left_word got %h expected a5c3", slot_cap[30:15]); end
        checks++; if ({slot_cap[31], slot_cap[14:0]} !== 16'h0) begin errors++; $display("FAIL dac_left_pad got %h expected 0000", {slot_cap[31], slot_cap[14:0]}); end
        checks++; if (n_trig_l - b_trig_l != 1 || n_trig_r - b_trig_r != 0)
            begin errors++; $display("FAIL dac_left_trig got L%0d R%0d expected L1 R0", n_trig_l - b_trig_l, n_trig_r - b_trig_r); end
        snap();
        slot(1'b1, 16'h0000);
        checks++; if (slot_cap[30:15] !== 16'h3C5A) begin errors++; $display("FAIL dac_right_word got %h expected 3c5a", slot_cap[30:15]); end
        checks++; if ({slot_cap[31], slot_cap[14:0]} !== 16'h0) begin errors++; $display("FAIL dac_right_pad got %h expected 0000", {slot_cap[31], slot_cap[14:0]}); end
        checks++; if (n_trig_l - b_trig_l != 0 || n_trig_r - b_trig_r != 1)
            begin errors++; $display("FAIL dac_right_trig got L%0d R%0d expected L0 R1", n_trig_l - b_trig_l, n_trig_r - b_trig_r); end
    endtask

    task automatic test_adc();
        snap();
        slot(1'b0, 16'h8001);
        checks++; if (ADC_LCHAN_DATA !== 16'h8001) begin errors++; $display("FAIL adc_left_data got %h expected 8001", ADC_LCHAN_DATA); end
        checks++; if (n_rdy_l - b_rdy_l != 1 || n_rdy_r - b_rdy_r != 0)
            begin errors++; $display("FAIL adc_left_ready got L%0d R%0d expected L1 R0", n_rdy_l - b_rdy_l, n_rdy_r - b_rdy_r); end
        snap();
        slot(1'b1, 16'h7FFE);
        checks++; if (ADC_RCHAN_DATA !== 16'h7FFE) begin errors++; $display("FAIL adc_right_data got %h expected 7ffe", ADC_RCHAN_DATA); end
        checks++; if (ADC_LCHAN_DATA !== 16'h8001) begin errors++; $display("FAIL adc_left_held got %h expected 8001", ADC_LCHAN_DATA); end
        checks++; if (n_rdy_l - b_rdy_l != 0 || n_rdy_r - b_rdy_r != 1)
            begin errors++; $display("FAIL adc_right_ready got L%0d R%0d expected L0 R1", n_rdy_l - b_rdy_l, n_rdy_r - b_rdy_r); end
        checks++; if (n_coinc != 0) begin errors++; $display("FAIL pulse_coincide got %0d expected 0", n_coinc); end
        checks++; if (FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL clean_frame_error got %b expected 0", FRAME_ERROR); end
    endtask

    task automatic test_frame_error();
        snap();
        // ADC LRCK goes left for only 10 BCLKs; DAC LRCK stays right throughout
        slot_cap = '0;
        slot_part(1'b1, 1'b0, 16'hFFFF, 0, 10);
        slot(1'b1, 16'h1234);
        checks++; if (FRAME_ERROR !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b expected 1", FRAME_ERROR); end
        checks++; if (n_rdy_l - b_rdy_l != 0) begin errors++; $display("FAIL ferr_no_ready got %0d expected 0", n_rdy_l - b_rdy_l); end
        checks++; if (ADC_LCHAN_DATA !== 16'h8001) begin errors++; $display("FAIL ferr_left_held got %h expected 8001", ADC_LCHAN_DATA); end
        checks++; if (n_rdy_r - b_rdy_r != 1) begin errors++; $display("FAIL ferr_next_ready got %0d expected 1", n_rdy_r - b_rdy_r); end
        checks++; if (ADC_RCHAN_DATA !== 16'h1234) begin errors++; $display("FAIL ferr_next_data got %h expected 1234", ADC_RCHAN_DATA); end
        checks++; if (n_trig_l - b_trig_l + n_trig_r - b_trig_r != 0)
            begin errors++; $display("FAIL ferr_dac_trig got %0d expected 0", n_trig_l - b_trig_l + n_trig_r - b_trig_r); end
    endtask

    task automatic test_enable();
        DAC_LCHAN_DATA = 16'hA5C3;
        slot_cap = '0;
        slot_part(1'b0, 1'b0, 16'h0000, 0, 4);   // DACDAT now carries bit 13 of A5C3
        checks++; if (AUD_DACDAT !== 1'b1) begin errors++; $display("FAIL en_pre_dacdat got %b expected 1", AUD_DACDAT); end
        ENABLE = 1'b0;
        repeat (4) @(negedge CLK);
        checks++; if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL en_off_dacdat got %b expected 0", AUD_DACDAT); end
        snap();
        slot_part(1'b0, 1'b0, 16'hFFFF, 4, 32);
        checks++; if (slot_cap[27:0] !== 28'h0) begin errors++; $display("FAIL en_off_slot got %h expected 0000000", slot_cap[27:0]); end
        slot(1'b1, 16'hFFFF);
        slot_cap = '0;
        slot_part(1'b0, 1'b0, 16'hFFFF, 0, 16);
        checks++; if (n_trig_l - b_trig_l + n_trig_r - b_trig_r + n_rdy_l - b_rdy_l + n_rdy_r - b_rdy_r != 0)
            begin errors++; $display("FAIL en_off_pulses got %0d expected 0", n_trig_l - b_trig_l + n_trig_r - b_trig_r + n_rdy_l - b_rdy_l + n_rdy_r - b_rdy_r); end
        checks++; if (FRAME_ERROR !== 1'b1 || ADC_RCHAN_DATA !== 16'h1234)
            begin errors++; $display("FAIL en_off_held got fe=%b r=%h expected fe=1 r=1234", FRAME_ERROR, ADC_RCHAN_DATA); end
        ENABLE = 1'b1;                            // re-enable mid left slot
        slot_part(1'b0, 1'b0, 16'hFFFF, 16, 32);
        snap();
        slot(1'b1, 16'hFFFF);                     // first edge: synchronise only
        checks++; if (slot_cap !== 32'h0) begin errors++; $display("FAIL en_sync_slot got %h expected 00000000", slot_cap); end
        checks++; if (n_trig_l - b_trig_l + n_trig_r - b_trig_r + n_rdy_l - b_rdy_l + n_rdy_r - b_rdy_r != 0)
            begin errors++; $display("FAIL en_sync_pulses got %0d expected 0", n_trig_l - b_trig_l + n_trig_r - b_trig_r + n_rdy_l - b_rdy_l + n_rdy_r - b_rdy_r); end
        snap();
        slot(1'b0, 16'h0F0F);
        checks++; if (slot_cap[30:15] !== 16'hA5C3) begin errors++; $display("FAIL en_resume_word got %h expected a5c3", slot_cap[30:15]); end
        checks++; if (n_trig_l - b_trig_l != 1) begin errors++; $display("FAIL en_resume_trig got %0d expected 1", n_trig_l - b_trig_l); end
        checks++; if (ADC_LCHAN_DATA !== 16'h0F0F || n_rdy_l - b_rdy_l != 1)
            begin errors++; $display("FAIL en_resume_adc got %h/%0d expected 0f0f/1", ADC_LCHAN_DATA, n_rdy_l - b_rdy_l); end
    endtask

    task automatic test_reset_midframe();
        DAC_RCHAN_DATA = 16'h3C5A;
        slot_cap = '0;
        slot_part(1'b1, 1'b1, 16'h0000, 0, 6);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL rst_mid_dacdat got %b expected 0", AUD_DACDAT); end
        checks++; if (ADC_LCHAN_DATA !== 16'h0 || ADC_RCHAN_DATA !== 16'h0)
            begin errors++; $display("FAIL rst_mid_adc got %h/%h expected 0000/0000", ADC_LCHAN_DATA, ADC_RCHAN_DATA); end
        checks++; if (FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_error got %b expected 0", FRAME_ERROR); end
        checks++; if ({DAC_STATE, ADC_STATE} !== 4'b0) begin errors++; $display("FAIL rst_mid_states got %b expected 0000", {DAC_STATE, ADC_STATE}); end
        RESET = 1'b0;
        snap();
        slot_part(1'b1, 1'b1, 16'h0000, 6, 32);
        checks++; if (slot_cap[25:0] !== 26'h0) begin errors++; $display("FAIL rst_rest_slot got %h expected 0000000", slot_cap[25:0]); end
        slot(1'b0, 16'h0000);
        checks++; if (slot_cap !== 32'h0 || n_trig_l - b_trig_l != 0)
            begin errors++; $display("FAIL rst_sync_slot got %h/%0d expected 00000000/0", slot_cap, n_trig_l - b_trig_l); end
        slot(1'b1, 16'h0000);
        checks++; if (slot_cap[30:15] !== 16'h3C5A || n_trig_r - b_trig_r != 1)
            begin errors++; $display("FAIL rst_first_frame got %h/%0d expected 3c5a/1", slot_cap[30:15], n_trig_r - b_trig_r); end
    endtask

    task automatic test_loopback();
        DAC_LCHAN_DATA = 16'h5A5A; DAC_RCHAN_DATA = 16'h00FF;
        adc_tie_high = 1'b1;
        ENABLE = 1'b1;
        slot(1'b0, 16'h0000);
        slot(1'b1, 16'h0000);
        snap();
        slot(1'b0, 16'h0000);
        checks++; if (ADC_LCHAN_DATA !== 16'h5A5A) begin errors++; $display("FAIL loop_left got %h expected 5a5a", ADC_LCHAN_DATA); end
        checks++; if (n_rdy_l - b_rdy_l != 1) begin errors++; $display("FAIL loop_left_ready got %0d expected 1", n_rdy_l - b_rdy_l); end
        checks++; if (slot_cap[30:15] !== 16'h5A5A) begin errors++; $display("FAIL loop_dac_word got %h expected 5a5a", slot_cap[30:15]); end
        slot(1'b1, 16'h0000);
        checks++; if (ADC_RCHAN_DATA !== 16'h00FF) begin errors++; $display("FAIL loop_right got %h expected 00ff", ADC_RCHAN_DATA); end
    endtask

    initial begin
        test_reset();
`ifdef AUD_SLAVE_LOOPBACK_EN
        test_loopback();
`else
        test_dac();
        test_adc();
        test_frame_error();
        test_enable();
        test_reset_midframe();
`endif
        checks++; if (n_coinc != 0) begin errors++; $display("FAIL final_coincide got %0d expected 0", n_coinc); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
